// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (IF / D) arbiter and sequencer in front of the memory
// controller. One transaction at a time: ISSUE strobes mem_valid for a cycle,
// WAIT counts out MEM_LAT cycles, RESP pulses the winner's ack with read data.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration when
// both ports request; undefined gives fixed D-over-IF priority.
//
// Handshake: a requester raises req with stable operands and holds them until
// it sees its one-cycle ack. The request is latched at the IDLE edge, so later
// operand changes are ignored. A req seen during the ack (RESP) cycle is not
// sampled; holding req high queues the next transaction, sampled in IDLE.
module mem_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [CPUAWIDTH-1:0] if_addr,
  output logic                 if_ack,
  output logic [DWIDTH-1:0]    if_rdata,
  input  logic                 d_req,
  input  logic                 d_rw,
  input  logic [CPUAWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0]    d_wdata,
  output logic                 d_ack,
  output logic [DWIDTH-1:0]    d_rdata,
  output logic                 mem_valid,
  output logic                 mem_rw,
  output logic [CPUAWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  output logic                 mem_data_oe,
  input  logic [DWIDTH-1:0]    mem_rdata,
  output logic                 busy,
  output logic                 grant_d,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Counter reload: WAIT exits when the counter reads zero, so MEM_LAT-1
  // gives exactly MEM_LAT WAIT cycles.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   grant_d_q, grant_d_d;
  logic [CPUAWIDTH-1:0]   addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic [DWIDTH-1:0]      wdata_q, wdata_d;
  logic [DWIDTH-1:0]      if_rdata_q, if_rdata_d;
  logic [DWIDTH-1:0]      d_rdata_q, d_rdata_d;
  logic                   d_wins;

  // Arbitration decision among the current requests
  always_comb begin
    d_wins = 1'b0;
`ifdef MEM_ARB_RR_EN
    // Under contention the port that did not win last time goes first.
    d_wins = d_req && (!if_req || !grant_d_q);
`else
    d_wins = d_req;
`endif
  end

  // Next-state, counter, latch and read-data capture logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d_d  = grant_d_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant_d_d = d_wins;
          if (d_wins) begin
            addr_d  = {d_addr[CPUAWIDTH-1:2], 2'b00};
            rw_d    = d_rw;
            wdata_d = d_wdata;
          end else begin
            addr_d  = {if_addr[CPUAWIDTH-1:2], 2'b00};
            rw_d    = 1'b1;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Read data is captured on the edge entering RESP.
          if (rw_q) begin
            if (grant_d_q) d_rdata_d  = mem_rdata;
            else           if_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      grant_d_q  <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_d_q  <= grant_d_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_valid   = (state_q == S_ISSUE);
  assign mem_rw      = rw_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_data_oe = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !rw_q;
  assign if_ack      = (state_q == S_RESP) && !grant_d_q;
  assign d_ack       = (state_q == S_RESP) && grant_d_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_d     = grant_d_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Main instance uses
// MEM_LAT=2 with a small word memory model; two extra instances (MEM_LAT=1
// and MEM_LAT=15) share the inputs and are used for the latency sweep.
// Cycle k after a sampling edge is the clock period ending at the k-th
// following rising edge; outputs are sampled on falling edges.
module tb_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_rw;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] mem_rdata;

  // main instance outputs
  logic        if_ack, d_ack, mem_valid, mem_rw, mem_data_oe, busy, grant_d;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  dbg_state;
  // MEM_LAT=1 instance outputs
  logic        if_ack_a, d_ack_a, mem_valid_a, mem_rw_a, mem_data_oe_a, busy_a, grant_d_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;
  logic [1:0]  dbg_state_a;
  // MEM_LAT=15 instance outputs
  logic        if_ack_b, d_ack_b, mem_valid_b, mem_rw_b, mem_data_oe_b, busy_b, grant_d_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;
  logic [1:0]  dbg_state_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_grant_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter #(.DWIDTH(32), .CPUAWIDTH(32), .MEM_LAT(L)) dut (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d), .dbg_state(dbg_state)
  );

  mem_arbiter #(.DWIDTH(32), .CPUAWIDTH(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_a), .d_rdata(d_rdata_a),
    .mem_valid(mem_valid_a), .mem_rw(mem_rw_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_data_oe(mem_data_oe_a), .mem_rdata(mem_rdata),
    .busy(busy_a), .grant_d(grant_d_a), .dbg_state(dbg_state_a)
  );

  mem_arbiter #(.DWIDTH(32), .CPUAWIDTH(32), .MEM_LAT(15)) dut_b (
    .clk(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_valid(mem_valid_b), .mem_rw(mem_rw_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_data_oe(mem_data_oe_b), .mem_rdata(mem_rdata),
    .busy(busy_b), .grant_d(grant_d_b), .dbg_state(dbg_state_b)
  );

  // memory model: 256 words, preloaded on reset, serves the main instance
  logic [31:0] mem_arr [256];
  logic [7:0]  last_idx;
  logic        ovr_en;
  logic [31:0] ovr_val;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
      mem_arr[8'h04] <= 32'hDEAD_BEEF;   // byte 0x10
      mem_arr[8'h40] <= 32'hA5A5_A5A5;   // byte 0x100
      last_idx <= 8'h0;
    end else if (mem_valid) begin
      last_idx <= mem_addr[9:2];
      if (!mem_rw) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = ovr_en ? ovr_val : mem_arr[last_idx];

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Single-port transaction driver; call on a falling edge with the DUT idle.
  task automatic txn(input string tag, input bit is_d, input bit rw,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata);
    int valid_at = 0, valid_cnt = 0, oe_cnt = 0, ack_at = 0, other = 0;
    logic exp_rw;
    exp_rw = is_d ? rw : 1'b1;
    if (is_d) begin
      d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    exp_q.push_back(exp_rdata);
    @(posedge clk);
    for (int k = 1; k <= 12 && ack_at == 0; k++) begin
      @(negedge clk);
      if (mem_valid) begin
        valid_cnt++;
        if (valid_at == 0) begin
          valid_at = k;
          chk({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
          chk({tag, "_mem_rw"}, {31'b0, mem_rw}, {31'b0, exp_rw});
        end
      end
      if (mem_data_oe) oe_cnt++;
      if (is_d ? if_ack : d_ack) other++;
      if (is_d ? d_ack : if_ack) begin
        ack_at = k;
        if_req = 1'b0; d_req = 1'b0;
        chk({tag, "_rdata"}, is_d ? d_rdata : if_rdata, exp_q.pop_front());
      end
    end
    if (ack_at == 0) begin
      if_req = 1'b0; d_req = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    chk({tag, "_ack_cycle"}, 32'(ack_at), 32'(L + 2));
    chk({tag, "_valid_cycle"}, 32'(valid_at), 32'd1);
    chk({tag, "_valid_count"}, 32'(valid_cnt), 32'd1);
    chk({tag, "_oe_count"}, 32'(oe_cnt), exp_rw ? 32'd0 : 32'(L + 1));
    chk({tag, "_other_ack"}, 32'(other), 32'd0);
    @(negedge clk);  // IDLE cycle
  endtask

  initial begin
    int n_acks, last_k, n_d, n_a, n_b, ack_a_at, ack_b_at;
    logic g;
    logic [31:0] rd_a, rd_b;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_rw = 1'b1;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    ovr_en = 1'b0; ovr_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_rw", {31'b0, mem_rw}, 32'd1);
    chk("rst_grant_d", {31'b0, grant_d}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_oe_acks", {29'b0, mem_data_oe, if_ack, d_ack}, 32'd0);

    // single fetch, unaligned address
    txn("fetch", 1'b0, 1'b1, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF);
    // store then load; store leaves d_rdata untouched
    txn("store", 1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0);
    txn("load", 1'b1, 1'b1, 32'h0000_0040, 32'h0, 32'h1234_5678);

    // contention: both requests held; D dropped after the third ack
`ifdef MEM_ARB_RR_EN
    exp_grant_q.push_back(32'd1); exp_grant_q.push_back(32'd0);
    exp_grant_q.push_back(32'd1); exp_grant_q.push_back(32'd0);
`else
    exp_grant_q.push_back(32'd1); exp_grant_q.push_back(32'd1);
    exp_grant_q.push_back(32'd1); exp_grant_q.push_back(32'd0);
`endif
    if_req = 1'b1; if_addr = 32'h0000_0100;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0000_0040;
    n_acks = 0; last_k = 0;
    @(posedge clk);
    for (int k = 1; k <= 40 && n_acks < 4; k++) begin
      @(negedge clk);
      if (d_ack || if_ack) begin
        g = d_ack;
        if (exp_grant_q.size() > 0) chk("cont_grant_port", {31'b0, g}, exp_grant_q.pop_front());
        else chk("cont_extra_ack", 32'd1, 32'd0);
        chk("cont_grant_d", {31'b0, grant_d}, {31'b0, g});
        if (g) chk("cont_d_rdata", d_rdata, 32'h1234_5678);
        else   chk("cont_if_rdata", if_rdata, 32'hA5A5_A5A5);
        if (n_acks > 0) chk("cont_ack_spacing", 32'(k - last_k), 32'(L + 3));
        last_k = k;
        n_acks++;
        if (n_acks == 3) d_req = 1'b0;
        if (n_acks == 4) if_req = 1'b0;
      end
    end
    chk("cont_ack_total", 32'(n_acks), 32'd4);
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // reset during WAIT of a D read
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0000_0040;
    @(posedge clk);
    @(negedge clk);
    chk("rstw_issue_valid", {31'b0, mem_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    #1;
    chk("rstw_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rstw_busy", {31'b0, busy}, 32'd0);
    chk("rstw_d_rdata", d_rdata, 32'd0);
    chk("rstw_state", {30'b0, dbg_state}, 32'd0);
    chk("rstw_mem_rw", {31'b0, mem_rw}, 32'd1);
    n_d = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (d_ack) n_d++;
    end
    chk("rstw_no_d_ack", 32'(n_d), 32'd0);
    chk("rstw_d_rdata_hold", d_rdata, 32'd0);
    txn("refetch", 1'b0, 1'b1, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF);

    // latency sweep on MEM_LAT=1 and MEM_LAT=15 instances
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ovr_en = 1'b1; ovr_val = 32'hBAD0_0000;
    if_req = 1'b1; if_addr = 32'h0000_0000;
    n_a = 0; n_b = 0; ack_a_at = 0; ack_b_at = 0; rd_a = '0; rd_b = '0;
    @(posedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) if_req = 1'b0;
      if (if_ack_a) begin
        n_a++;
        if (ack_a_at == 0) begin ack_a_at = k; rd_a = if_rdata_a; end
      end
      if (if_ack_b) begin
        n_b++;
        if (ack_b_at == 0) begin ack_b_at = k; rd_b = if_rdata_b; end
      end
      // value is stable only during the cycle ending at the capture edge
      if (k == 2)       ovr_val = 32'h1111_0001;
      else if (k == 16) ovr_val = 32'hF00D_000F;
      else              ovr_val = 32'hBAD0_0000 | 32'(k);
    end
    chk("lat1_ack_cycle", 32'(ack_a_at), 32'd3);
    chk("lat15_ack_cycle", 32'(ack_b_at), 32'd17);
    chk("lat1_rdata", rd_a, 32'h1111_0001);
    chk("lat15_rdata", rd_b, 32'hF00D_000F);
    chk("lat1_ack_count", 32'(n_a), 32'd1);
    chk("lat15_ack_count", 32'(n_b), 32'd1);
    chk("lat1_rdata_hold", if_rdata_a, 32'h1111_0001);
    ovr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the memory controller.
- Shares the single memory port between instruction fetch (IF) and the load/store data port (D).
- Performs one transaction at a time: issues a one-cycle valid strobe, waits a fixed memory latency, captures read data and returns a one-cycle ack to the winning requester.
- Sits between the CPU front end / memory stage and the memory controller.

Parameters:
DWIDTH, 32, data bus width
CPUAWIDTH, 32, CPU byte-address width
MEM_LAT, 2, cycles from the valid strobe to read data stable on mem_rdata; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  instruction fetch request (always a read)
if_addr  in  CPUAWIDTH  fetch byte address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DWIDTH  fetched word
d_req  in  1  data request
d_rw  in  1  1 = read, 0 = write
d_addr  in  CPUAWIDTH  data byte address
d_wdata  in  DWIDTH  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DWIDTH  load data
mem_valid  out  1  strobe to memory controller
mem_rw  out  1  1 = read, 0 = write
mem_addr  out  CPUAWIDTH  word-aligned address
mem_wdata  out  DWIDTH  write data, driven onto the shared bus at top level
mem_data_oe  out  1  tristate enable for mem_wdata
mem_rdata  in  DWIDTH  bus value as read back
busy  out  1  high in any state except IDLE
grant_d  out  1  1 = current or last grant went to D, 0 = went to IF

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Registered state, 4-bit wait counter.
- IDLE:
  - At a rising edge with any request high: choose a winner, latch its addr/rw/wdata, move to ISSUE.
  - At a rising edge with no request: stay in IDLE.
- ISSUE (1 cycle):
  - mem_valid=1; mem_rw, mem_addr and mem_wdata come from the latched values.
  - mem_addr[1:0] is forced to 2'b00.
  - IF is always issued with rw=1.
  - Counter loads MEM_LAT-1. Next state: WAIT.
- WAIT:
  - mem_valid=0; latched outputs held.
  - Counter decrements each cycle; at 0 go to RESP. WAIT lasts exactly MEM_LAT cycles.
- RESP (1 cycle):
  - Winner's ack=1.
  - Reads only: mem_rdata is captured into the winner's rdata register at the RESP entry edge, so it is valid while ack is high.
  - rdata registers hold their value until the next read to the same port; writes never change d_rdata.
  - Next state: IDLE.
- mem_data_oe: 1 during ISSUE and WAIT of a write only; otherwise 0.
- Latency: ack asserts MEM_LAT+2 cycles after the edge that sampled the request. Back-to-back transactions complete every MEM_LAT+3 cycles.
- Handshake:
  - A requester holds req and its operands stable until it sees ack.
  - req sampled in the ack cycle is ignored (the arbiter is in RESP). The requester may keep req high to queue the next transaction, which is resampled in IDLE.
  - Operand changes after the IDLE latch edge have no effect.
- Arbitration (default): fixed priority, D over IF. grant_d updates at the latch edge.
- Simultaneous requests: exactly one winner; the loser waits for the next IDLE.
- Reset (asserted any time, including mid-transaction):
  - Go to IDLE immediately.
  - mem_valid=0, mem_data_oe=0, if_ack=0, d_ack=0.
  - if_rdata=0, d_rdata=0, mem_addr/mem_wdata=0, mem_rw=1, grant_d=0, counter=0.
  - The in-flight transaction is abandoned with no ack.
- Deassertion of reset: first possible latch is the next rising edge.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. When both request, the port not equal to grant_d wins (after reset grant_d=0, so the first contended grant goes to D). A single requester always wins regardless of history.
- Undefined: fixed D-over-IF priority as above; IF can be starved by continuous D traffic.

Test Plan:
- Single fetch: MEM_LAT=2, if_req=1, if_addr=0x0000_0013, memory returns 0xDEAD_BEEF → mem_valid one cycle with mem_addr=0x0000_0010, mem_rw=1; if_ack 4 cycles after the sampling edge; if_rdata=0xDEAD_BEEF.
- Store then load: d_rw=0, d_addr=0x40, d_wdata=0x1234_5678 → mem_data_oe high 3 cycles, d_ack with d_rdata unchanged (0). Then read 0x40 → d_rdata=0x1234_5678.
- Contention, fixed priority: if_req and d_req held high for 3 transactions → grants D, D, D; IF never acked while d_req stays high. Drop d_req → IF granted next.
- Contention, MEM_ARB_RR_EN defined: both held high → grants D, IF, D, IF; acks spaced MEM_LAT+3=5 cycles apart.
- Reset mid-WAIT: assert reset during WAIT of a D read → immediately mem_valid=0, busy=0, no d_ack ever, d_rdata=0. After release, a new if_req completes normally.
- Latency sweep: MEM_LAT=1 and MEM_LAT=15 → ack at 3 and 17 cycles respectively after the sampling edge; mem_rdata sampled exactly at RESP entry (bench changes mem_rdata one cycle later and checks the captured value).
